// File: rtl/sd_hex_line_parser_if.sv
// Byte-stream in / packed-line out bundle for sd_hex_line_parser.
// The master drives bytes and ready; the slave (the parser) returns lines, valid and status pulses.
interface sd_hex_line_parser_if #(
    parameter int unsigned OW = 64
);
    logic          outreq;
    logic [7:0]    outbyte;
    logic [OW-1:0] sd_data;
    logic          sd_data_valid;
    logic          sd_data_ready;
    logic          parse_err;
    logic          ovf_err;
    logic          stream_done;

    modport master (
        output outreq, outbyte, sd_data_ready,
        input  sd_data, sd_data_valid, parse_err, ovf_err, stream_done
    );

    modport slave (
        input  outreq, outbyte, sd_data_ready,
        output sd_data, sd_data_valid, parse_err, ovf_err, stream_done
    );
endinterface

// File: rtl/sd_hex_line_parser.sv
// ASCII-hex line parser: LF-started lines of comma-terminated hex fields -> one packed word per line.
// Optional build macro SD_LINE_CNT_EN adds a 16-bit count of lines loaded into the output register.
module sd_hex_line_parser #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned WORDS_PER_LINE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sd_hex_line_parser_if.slave   bus
`ifdef SD_LINE_CNT_EN
    ,
    output logic [15:0]           line_cnt
`endif
);
    localparam int unsigned FW = 4 * DIGITS;
    localparam int unsigned OW = WORDS_PER_LINE * FW;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned IW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SLASH = 8'h2F;

    typedef enum logic [0:0] {IDLE, COLLECT} state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [FW-1:0]  fields_q [WORDS_PER_LINE];
    logic [FW-1:0]  fields_d [WORDS_PER_LINE];
    logic [OW-1:0]  data_q, data_d;
    logic           valid_q, valid_d;
    logic           perr_q, perr_d;
    logic           ovf_q, ovf_d;
    logic           sdone_q, sdone_d;
    logic           load;
    logic           line_done;
    logic [OW-1:0]  line_w;
    logic           is_hex;
    logic [3:0]     nib;
`ifdef SD_LINE_CNT_EN
    logic [15:0]    lcnt_q, lcnt_d;
`endif

    always_comb begin
        is_hex = 1'b0;
        nib    = '0;
        if (bus.outbyte >= "0" && bus.outbyte <= "9") begin
            is_hex = 1'b1;
            nib    = bus.outbyte[3:0];
        end else if ((bus.outbyte >= "A" && bus.outbyte <= "F") ||
                     (bus.outbyte >= "a" && bus.outbyte <= "f")) begin
            is_hex = 1'b1;
            nib    = bus.outbyte[3:0] + 4'd9;
        end
    end

    // Completed line: stored fields in the upper slots, the live accumulator is the last field.
    always_comb begin
        line_w = '0;
        for (int unsigned i = 0; i + 1 < WORDS_PER_LINE; i++) begin
            line_w[OW-1-i*FW -: FW] = fields_q[i];
        end
        line_w[FW-1:0] = acc_q;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        fields_d  = fields_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = 1'b0;
        ovf_d     = 1'b0;
        sdone_d   = 1'b0;
        line_done = 1'b0;
        load      = 1'b0;

        if (bus.outreq && bus.outbyte != CH_CR) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.outbyte == CH_LF) begin
                        state_d = COLLECT;
                        acc_d   = '0;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else if (bus.outbyte == CH_SLASH) begin
                        sdone_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (is_hex) begin
                        if (cnt_q == CW'(DIGITS)) begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            acc_d = (acc_q << 4) | FW'(nib);
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (bus.outbyte == CH_COMMA) begin
                        if (cnt_q == '0) begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
                        end else if (idx_q == IW'(WORDS_PER_LINE - 1)) begin
                            line_done = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            fields_d[idx_q] = acc_q;
                            idx_d = idx_q + IW'(1);
                            acc_d = '0;
                            cnt_d = '0;
                        end
                    end else if (bus.outbyte == CH_LF) begin
                        acc_d = '0;
                        cnt_d = '0;
                        idx_d = '0;
                    end else if (bus.outbyte == CH_SLASH) begin
                        sdone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A line can load into the holding register in the same cycle the old one is consumed.
        if (line_done) begin
            if (!valid_q || bus.sd_data_ready) begin
                data_d  = line_w;
                valid_d = 1'b1;
                load    = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && bus.sd_data_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef SD_LINE_CNT_EN
    always_comb begin
        lcnt_d = lcnt_q;
        if (sdone_d) begin
            lcnt_d = '0;
        end else if (load) begin
            lcnt_d = lcnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            fields_q <= '{default: '0};
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sdone_q  <= 1'b0;
`ifdef SD_LINE_CNT_EN
            lcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fields_q <= fields_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ovf_q    <= ovf_d;
            sdone_q  <= sdone_d;
`ifdef SD_LINE_CNT_EN
            lcnt_q   <= lcnt_d;
`endif
        end
    end

    assign bus.sd_data       = data_q;
    assign bus.sd_data_valid = valid_q;
    assign bus.parse_err     = perr_q;
    assign bus.ovf_err       = ovf_q;
    assign bus.stream_done   = sdone_q;
`ifdef SD_LINE_CNT_EN
    assign line_cnt          = lcnt_q;
`endif

endmodule

// File: tb/tb_sd_hex_line_parser.sv
// Self-checking bench for sd_hex_line_parser: directed vector table, hand sequences, and
// randomized byte streams compared each cycle against a queue-based line model.
module tb_sd_hex_line_parser;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned NW     = 2;
    localparam int unsigned FW     = 4 * DIGITS;
    localparam int unsigned OW     = NW * FW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_hex_line_parser_if #(.OW(OW)) bus ();
`ifdef SD_LINE_CNT_EN
    logic [15:0] line_cnt;
`endif

    sd_hex_line_parser #(
        .DIGITS(DIGITS),
        .WORDS_PER_LINE(NW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SD_LINE_CNT_EN
        ,
        .line_cnt(line_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a line is a list of field values built from a list of digit values.
    bit               m_valid;
    logic [63:0]      m_data;
    bit               m_inline;
    logic [FW-1:0]    m_fields[$];
    int unsigned      m_digits[$];
    int unsigned      m_cnt;
    bit               e_perr, e_ovf, e_sdone;

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_inline = 0; m_cnt = 0;
        m_fields.delete(); m_digits.delete();
        e_perr = 0; e_ovf = 0; e_sdone = 0;
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
        return -1;
    endfunction

    task automatic model_step(input bit req, input logic [7:0] b, input bit rdy);
        bit          done = 0;
        bit          perr = 0;
        logic [63:0] line = '0;
        logic [FW-1:0] v;
        int          h;
        e_perr = 0; e_ovf = 0; e_sdone = 0;
        if (req && b != 8'h0D) begin
            h = hexval(b);
            if (!m_inline) begin
                if (b == 8'h0A) begin
                    m_inline = 1; m_fields.delete(); m_digits.delete();
                end else if (b == 8'h2F) e_sdone = 1;
            end else if (h >= 0) begin
                if (m_digits.size() == DIGITS) perr = 1;
                else m_digits.push_back(h);
            end else if (b == 8'h2C) begin
                if (m_digits.size() == 0) perr = 1;
                else begin
                    v = '0;
                    foreach (m_digits[k]) v = v * 16 + FW'(m_digits[k]);
                    m_fields.push_back(v);
                    m_digits.delete();
                    if (m_fields.size() == NW) begin
                        done = 1;
                        foreach (m_fields[k]) line = (line << FW) | 64'(m_fields[k]);
                        m_inline = 0;
                    end
                end
            end else if (b == 8'h0A) begin
                m_fields.delete(); m_digits.delete();
            end else if (b == 8'h2F) begin
                e_sdone = 1; m_inline = 0;
            end else perr = 1;
            if (perr) begin
                e_perr = 1; m_inline = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data = line; m_valid = 1; m_cnt = (m_cnt + 1) & 32'hFFFF;
            end else e_ovf = 1;
        end else if (m_valid && rdy) m_valid = 0;
        if (e_sdone) m_cnt = 0;
    endtask

    // Drive one byte slot at the falling edge, then compare after the next rising edge.
    task automatic cycle(input bit req, input logic [7:0] b, input bit rdy);
        bus.outreq = req; bus.outbyte = b; bus.sd_data_ready = rdy;
        model_step(req, b, rdy);
        @(posedge clk);
        @(negedge clk);
        chk("valid", 64'(bus.sd_data_valid), 64'(m_valid));
        chk("data", bus.sd_data, m_data);
        chk("parse_err", 64'(bus.parse_err), 64'(e_perr));
        chk("ovf_err", 64'(bus.ovf_err), 64'(e_ovf));
        chk("stream_done", 64'(bus.stream_done), 64'(e_sdone));
`ifdef SD_LINE_CNT_EN
        chk("line_cnt", 64'(line_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic send(input string s, input bit rdy,
                        output bit saw_perr, output bit saw_sdone, output bit early_valid);
        saw_perr = 0; saw_sdone = 0; early_valid = 0;
        for (int i = 0; i < s.len(); i++) begin
            cycle(1'b1, s[i], rdy);
            saw_perr  |= bus.parse_err;
            saw_sdone |= bus.stream_done;
            if (i < s.len() - 1) early_valid |= bus.sd_data_valid;
        end
    endtask

    task automatic do_reset();
        bus.outreq = 0; bus.outbyte = '0; bus.sd_data_ready = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string       txt;
        logic [63:0] data;
        bit          valid;
        bit          perr;
        bit          sdone;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit p, s, e;
        string hexs = "0123456789abcdefABCDEF";
        string bads = "Gz: g@";
        int r;
        logic [7:0] b;
        bit req, rdy;

        vecs[0] = '{"\n0000ABCD,12345678,", 64'h0000ABCD_12345678, 1, 0, 0};
        vecs[1] = '{"\nff,1a2b,",            64'h000000FF_00001A2B, 1, 0, 0};
        vecs[2] = '{"\015\nf\015f,\0151a2\015b,", 64'h000000FF_00001A2B, 1, 0, 0};
        vecs[3] = '{"\n123456789,",          64'h0, 0, 1, 0};
        vecs[4] = '{"\n12G4,1,",             64'h0, 0, 1, 0};
        vecs[5] = '{"\n,5,",                 64'h0, 0, 1, 0};
        vecs[6] = '{"\nDEADBEEF,00000000,",  64'hDEADBEEF_00000000, 1, 0, 0};
        vecs[7] = '{$sformatf("\n12,%c", 8'h2F), 64'h0, 0, 0, 1};
        vecs[8] = '{"\n1,\n7,8,",            64'h00000007_00000008, 1, 0, 0};

        @(negedge clk);
        do_reset();
        chk("reset valid", 64'(bus.sd_data_valid), 64'h0);
        chk("reset data", bus.sd_data, 64'h0);
        chk("reset parse_err", 64'(bus.parse_err), 64'h0);
        chk("reset ovf_err", 64'(bus.ovf_err), 64'h0);
        chk("reset stream_done", 64'(bus.stream_done), 64'h0);

        foreach (vecs[i]) begin
            send(vecs[i].txt, 1'b1, p, s, e);
            chk($sformatf("vec%0d valid", i), 64'(bus.sd_data_valid), 64'(vecs[i].valid));
            if (vecs[i].valid) chk($sformatf("vec%0d data", i), bus.sd_data, vecs[i].data);
            chk($sformatf("vec%0d parse_err seen", i), 64'(p), 64'(vecs[i].perr));
            chk($sformatf("vec%0d stream_done seen", i), 64'(s), 64'(vecs[i].sdone));
            chk($sformatf("vec%0d early valid", i), 64'(e), 64'h0);
        end

        // Backpressure: second line overflows, third loads on the same cycle the first is taken.
        cycle(1'b0, 8'h00, 1'b1);
        send("\n1,2,", 1'b0, p, s, e);
        chk("bp first valid", 64'(bus.sd_data_valid), 64'h1);
        chk("bp first data", bus.sd_data, 64'h00000001_00000002);
        send("\n3,4,", 1'b0, p, s, e);
        chk("bp ovf pulse", 64'(bus.ovf_err), 64'h1);
        chk("bp held data", bus.sd_data, 64'h00000001_00000002);
        send("\n5,6", 1'b0, p, s, e);
        cycle(1'b1, 8'h2C, 1'b1);
        chk("bp third valid", 64'(bus.sd_data_valid), 64'h1);
        chk("bp third data", bus.sd_data, 64'h00000005_00000006);
        cycle(1'b0, 8'h00, 1'b1);
        chk("bp drained", 64'(bus.sd_data_valid), 64'h0);

        // Asynchronous reset in the middle of a field with a line pending.
        send("\n7,8,", 1'b0, p, s, e);
        send("\n12", 1'b0, p, s, e);
        bus.outreq = 0;
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", 64'(bus.sd_data_valid), 64'h0);
        chk("async rst data", bus.sd_data, 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send("\nA,B,", 1'b1, p, s, e);
        chk("after rst data", bus.sd_data, 64'h0000000A_0000000B);

`ifdef SD_LINE_CNT_EN
        do_reset();
        send("\n1,1,", 1'b1, p, s, e);
        send("\n2,2,", 1'b1, p, s, e);
        send("\n3,3,", 1'b1, p, s, e);
        chk("line_cnt three", 64'(line_cnt), 64'd3);
        cycle(1'b1, 8'h2F, 1'b1);
        chk("line_cnt cleared", 64'(line_cnt), 64'd0);
`endif

        // Randomized byte stream with random ready, checked every cycle by the model.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            req = 1'b1;
            if (r < 8) begin
                req = 1'b0; b = 8'($urandom_range(0, 255));
            end else if (r < 50) b = hexs[$urandom_range(0, hexs.len() - 1)];
            else if (r < 66) b = 8'h2C;
            else if (r < 76) b = 8'h0A;
            else if (r < 81) b = 8'h0D;
            else if (r < 84) b = 8'h2F;
            else b = bads[$urandom_range(0, bads.len() - 1)];
            rdy = ($urandom_range(0, 9) < 7);
            cycle(req, b, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
